// File: rtl/multi_bank_loader_if.sv
// Load-path bundle between the serial pad side and the multi-bank SRAM loader.
// Latency: n/a (wires only).
// Backpressure: none; data_ready gates the stream, the loader never stalls it.
// Build option: LOADER_PARITY_EN adds the sticky parity_err flag.
interface multi_bank_loader_if #(
    parameter int NUM_BANKS = 5,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 10
);
    localparam int SEL_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    logic                 ser_in;
    logic                 data_ready;
    logic [SEL_W-1:0]     bank_sel;
    logic                 clear;
    logic [NUM_BANKS-1:0] we;
    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    wdata;
    logic                 busy;
    logic [NUM_BANKS-1:0] full;
    logic                 overflow;
`ifdef LOADER_PARITY_EN
    logic                 parity_err;
`endif

    modport master (
        output ser_in, data_ready, bank_sel, clear,
        input  we, addr, wdata, busy, full, overflow
`ifdef LOADER_PARITY_EN
        , input parity_err
`endif
    );

    modport slave (
        input  ser_in, data_ready, bank_sel, clear,
        output we, addr, wdata, busy, full, overflow
`ifdef LOADER_PARITY_EN
        , output parity_err
`endif
    );
endinterface

// File: rtl/multi_bank_loader.sv
// Deserialises an MSB-first bit stream into words and writes each to its bank at a per-bank pointer.
// Latency: write strobe/addr/data registered on the edge that samples the final bit of a word.
// Backpressure: none; words to a full or nonexistent bank are dropped and flagged in sticky overflow.
// Build option: LOADER_PARITY_EN appends an even-parity bit per word and exposes parity_err.
module multi_bank_loader #(
    parameter int NUM_BANKS  = 5,
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 10,
    parameter int BANK_DEPTH = 1024
) (
    input logic               clk,
    input logic               reset,
    multi_bank_loader_if.slave lb
);
    localparam int SEL_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int CNT_W = $clog2(DATA_W + 1);
`ifdef LOADER_PARITY_EN
    // The whole word must be held while waiting for the parity bit.
    localparam int SR_W  = DATA_W;
`else
    // The last bit is taken straight from ser_in, so only DATA_W-1 bits are stored.
    localparam int SR_W  = DATA_W - 1;
`endif
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BANK_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT
`ifdef LOADER_PARITY_EN
        , ST_PARITY
`endif
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [SR_W-1:0]      r_sr;
    logic [SEL_W-1:0]     r_bank;
    logic [NUM_BANKS-1:0] r_we;
    logic [NUM_BANKS-1:0] r_full;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic                 r_overflow;
    logic [ADDR_W-1:0]    r_ptr [NUM_BANKS];

    logic                 w_shift;
    logic                 w_done;
    logic                 w_bank_ok;
    logic                 w_par_bad;
    logic [DATA_W-1:0]    w_word;
`ifdef LOADER_PARITY_EN
    logic                 r_parity_err;
`endif

    // State register; clear is folded into the next-state logic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state, shift enable and word-complete detection; clear overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_shift     = 1'b0;
        w_done      = 1'b0;
        w_par_bad   = 1'b0;
`ifdef LOADER_PARITY_EN
        w_word      = r_sr;
`else
        w_word      = {r_sr, lb.ser_in};
`endif
        case (r_state)
            ST_IDLE: begin
                if (lb.data_ready) begin
                    w_shift     = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (lb.data_ready) begin
                    w_shift = 1'b1;
                    if (r_cnt == LAST_BIT) begin
`ifdef LOADER_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_done      = 1'b1;
                        w_state_nxt = ST_IDLE;
`endif
                    end
                end
            end
`ifdef LOADER_PARITY_EN
            ST_PARITY: begin
                if (lb.data_ready) begin
                    w_done      = 1'b1;
                    w_par_bad   = ((^r_sr) != lb.ser_in);
                    w_state_nxt = ST_IDLE;
                end
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
        if (lb.clear) begin
            w_state_nxt = ST_IDLE;
            w_shift     = 1'b0;
            w_done      = 1'b0;
            w_par_bad   = 1'b0;
        end
    end

    // Target bank exists and still has room.
    always_comb begin
        w_bank_ok = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (r_bank == SEL_W'(b) && !r_full[b]) w_bank_ok = 1'b1;
        end
    end

    // Shift register, bit counter and bank latch (bank captured with the first bit).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sr   <= '0;
            r_cnt  <= '0;
            r_bank <= '0;
        end else if (lb.clear) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_shift) begin
                r_sr <= SR_W'({r_sr, lb.ser_in});
                if (r_state == ST_IDLE) r_bank <= lb.bank_sel;
            end
            if (w_done)
                r_cnt <= '0;
            else if (w_shift)
                r_cnt <= (r_state == ST_IDLE) ? CNT_W'(1) : r_cnt + 1'b1;
        end
    end

    // Commit stage: one-cycle write strobe, per-bank pointers, sticky full/overflow flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we       <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_full     <= '0;
            r_overflow <= 1'b0;
            for (int b = 0; b < NUM_BANKS; b++) r_ptr[b] <= '0;
`ifdef LOADER_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_we <= '0;
            if (lb.clear) begin
                r_full     <= '0;
                r_overflow <= 1'b0;
                for (int b = 0; b < NUM_BANKS; b++) r_ptr[b] <= '0;
`ifdef LOADER_PARITY_EN
                r_parity_err <= 1'b0;
`endif
            end else if (w_done) begin
                if (w_par_bad) begin
`ifdef LOADER_PARITY_EN
                    r_parity_err <= 1'b1;
`endif
                end else if (w_bank_ok) begin
                    for (int b = 0; b < NUM_BANKS; b++) begin
                        if (r_bank == SEL_W'(b)) begin
                            r_we[b] <= 1'b1;
                            r_addr  <= r_ptr[b];
                            r_wdata <= w_word;
                            // Last slot: mark full and leave the pointer parked there.
                            if (r_ptr[b] == LAST_ADDR) r_full[b] <= 1'b1;
                            else                       r_ptr[b]  <= r_ptr[b] + 1'b1;
                        end
                    end
                end else begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    assign lb.we       = r_we;
    assign lb.addr     = r_addr;
    assign lb.wdata    = r_wdata;
    assign lb.full     = r_full;
    assign lb.overflow = r_overflow;
    assign lb.busy     = (r_state != ST_IDLE);
`ifdef LOADER_PARITY_EN
    assign lb.parity_err = r_parity_err;
`endif
endmodule

// File: doc/multi_bank_loader.md
# multi_bank_loader

- Parametrised successor to the fixed single-deserializer load path.
- Receives a gated serial bit stream and assembles it into DATA_W-bit words.
- Steers each word into one of NUM_BANKS SRAM banks, with an independent auto-incrementing write pointer per bank.
- Sits between the serial pad interface and the weight/neuron/bias/parameter SRAM macros. It replaces the separate deserializer plus controller address logic used during load mode.

## Interface

Parameters:
- NUM_BANKS, default 5: number of SRAM banks served.
- DATA_W, default 8: word width; bits arrive MSB-first.
- ADDR_W, default 10: address width shared by all banks.
- BANK_DEPTH, default 1024: words per bank; must be ≤ 2^ADDR_W.

Ports:
- clk, input, 1: sole clock; all state updates on its rising edge.
- reset, input, 1: asynchronous, active-high; clears all state immediately.
- ser_in, input, 1: serial data bit.
- data_ready, input, 1: ser_in is valid this cycle; shifted in.
- bank_sel, input, $clog2(NUM_BANKS): target bank; latched with the first bit of each word.
- clear, input, 1: synchronous one-cycle pulse; zeroes pointers, flags and any partial word.
- we, output, NUM_BANKS: one-hot write enable, one cycle per word.
- addr, output, ADDR_W: write address, shared across banks.
- wdata, output, DATA_W: write data.
- busy, output, 1: a word is partially received.
- full, output, NUM_BANKS: bank has received BANK_DEPTH words.
- overflow, output, 1: sticky; a word was dropped.

## Operation

State machine:
- IDLE: bit count 0; busy=0.
  - data_ready=1 → SHIFT. The bit is shifted in, bank_sel is latched and the count becomes 1.
- SHIFT: each cycle with data_ready=1 shifts one bit in, `sr <= {sr[DATA_W-2:0], ser_in}`.
  - data_ready=0 pauses the shift; it does not abort, and partial bits are held indefinitely.
  - When bit DATA_W is shifted, the word is complete and the FSM returns to IDLE.
  - With LOADER_PARITY_EN, the FSM goes to PARITY instead.
- PARITY (macro only): the next data_ready=1 bit is the even-parity bit; the word then completes and the FSM returns to IDLE.

Word commit (registered output stage, independent of the FSM):
- On word complete, if the latched bank b < NUM_BANKS and full[b]=0:
  - we[b]=1, addr=ptr[b], wdata=sr for exactly one cycle.
  - ptr[b] then increments.
  - If ptr[b] was BANK_DEPTH-1, full[b] sets and ptr[b] holds; it does not wrap.
- Otherwise (bank out of range, or bank full): the word is dropped, we stays 0, and overflow sets.

Other rules:
- addr and wdata hold their last committed values when we=0.
- clear has priority over everything in the same cycle:
  - ptr=0, full=0, overflow=0, bit count=0, FSM→IDLE, we=0 next cycle.
  - A word completing in the same cycle is discarded.
  - A bit presented with clear is not shifted.
- Reset mid-word: all state clears asynchronously; the partial word is lost.

## Timing

- Reset values: we=0, addr=0, wdata=0, busy=0, full=0, overflow=0, all ptr=0, FSM=IDLE.
- Latency: the final bit is sampled at edge N; we/addr/wdata are valid from edge N until edge N+1.
- Back-to-back words with no gap are supported. The first bit of word k+1 may be sampled at edge N+1 while word k is being written.
- busy rises the cycle after the first bit is sampled and falls the cycle after word completion.
- full[b] rises in the same cycle as the write of the last word to bank b.
- overflow rises the cycle after a dropped word completes.

## Configuration

- LOADER_PARITY_EN defined:
  - Each word is followed by one even-parity bit, so DATA_W+1 bits per word.
  - Parity mismatch drops the word: no write, no pointer advance.
  - The sticky output parity_err (1 bit, reset 0, cleared by clear) sets.
- LOADER_PARITY_EN undefined: no PARITY state, no parity_err port, DATA_W bits per word.

## Test plan

Configuration for all scenarios: NUM_BANKS=4, DATA_W=8, BANK_DEPTH=4.

- Single word: bank_sel=2, shift 0xA5 with data_ready held high → we=4'b0100, addr=0, wdata=0xA5 one cycle after the 8th bit; busy was 1 during bits 2–8.
- Paused stream: shift 0x3C to bank 0 with data_ready low for 5 cycles after bit 4 → single write of 0x3C at addr 0; no spurious we.
- Fill and overflow: 5 consecutive words 0x01..0x05 to bank 1 → writes at addr 0..3; full=4'b0010 with the 4th write; 5th dropped, overflow=1, ptr stays 3.
- Interleaved banks, back-to-back: 0x11→b0, 0x22→b3, 0x33→b0 with no gaps → writes (b0,0,0x11), (b3,0,0x22), (b0,1,0x33) on cycles 9, 17, 25.
- Clear/reset mid-word: clear asserted after bit 5 of a word to bank 0, then 0x77 to bank 0 → single write of 0x77 at addr 0; same result with reset pulsed mid-word.
- Parity (macro on): 0x0F with parity 0 → written; 0x0F with parity 1 → no write, parity_err=1.
